// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: NUM_REQ requesters each presenting valid/addr/data and
// receiving a ready (grant) back from the register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
);
  localparam int AW = $clog2(WIDTH);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][AW-1:0]    req_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NUM_REQ
// writeback sources. Define REGFILE_WB_ARB_STALL_CNT_EN to add the stall_cnt counter.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  localparam int AW = $clog2(WIDTH),
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  regfile_wb_arbiter_if.slave   req,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic [GW-1:0]         grant_id
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // Handshake: a write transfers on the rising edge where req_valid[i] && req_ready[i];
  // a requester holds valid/addr/data stable until then, and ready never depends on
  // anything but valid, the pointer, flush and rst.

  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant_idx;
  logic          grant_vld;
  logic          grant_ok;
  logic [GW-1:0] rr_nxt;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return GW'(s);
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_vld && req.req_valid[wrap_idx(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = wrap_idx(rr_ptr, k);
      end
    end
  end

  assign grant_ok = grant_vld && !flush && !rst;
  assign rr_nxt   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  always_comb begin
    req.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req.req_ready[i] = grant_ok && (grant_idx == GW'(i));
    end
  end

  // Writes to x0 complete the handshake and update addr/data, but never pulse wr_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      wr_en    <= 1'b0;
      rr_ptr   <= '0;
    end else if (grant_vld) begin
      wr_en    <= (req.req_addr[grant_idx] != '0);
      wr_addr  <= req.req_addr[grant_idx];
      wr_data  <= req.req_data[grant_idx];
      grant_id <= grant_idx;
      rr_ptr   <= rr_nxt;
    end else begin
      wr_en    <= 1'b0;
    end
  end

`ifdef REGFILE_WB_ARB_STALL_CNT_EN
  // Counts edges where some requester waits, flush-suppressed cycles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|(req.req_valid & ~req.req_ready)) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NUM_REQ=2, WIDTH=32) with a write scoreboard.
module tb_regfile_wb_arbiter;
  localparam int NUM_REQ = 2;
  localparam int WIDTH   = 32;
  localparam int AW      = 5;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             grant_id;
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [AW+WIDTH-1:0] exp_q[$];
  logic [AW+WIDTH-1:0] exp_w;

  regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) rif ();

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .req      (rif),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .grant_id (grant_id)
`ifdef REGFILE_WB_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    rif.req_valid[i] = v;
    rif.req_addr[i]  = a;
    rif.req_data[i]  = d;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (a != '0) exp_q.push_back({a, d});
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    #3 rst = 1'b0;
  endtask

  // scoreboard: every wr_en pulse must match the oldest expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("sb_write", 64'({wr_addr, wr_data}), 64'(exp_w));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    rif.req_valid = '0;
    rif.req_addr  = '0;
    rif.req_data  = '0;

    // ready held low during reset even with a request present
    tick();
    set_req(0, 1'b1, 5'd7, 32'h77);
    #1;
    check("rst_ready", 64'(rif.req_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    set_req(0, 1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b0;

    // reset then idle
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle", 64'({wr_en, wr_addr, wr_data, grant_id, rif.req_ready}), 64'd0);
    end

    // single write
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    push_exp(5'd5, 32'hDEADBEEF);
    #1;
    check("single_ready", 64'(rif.req_ready), 64'b01);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("single_wr_en", 64'(wr_en), 64'd1);
    check("single_wr_addr", 64'(wr_addr), 64'd5);
    check("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    check("single_grant_id", 64'(grant_id), 64'd0);
    tick();
    check("single_wr_en_off", 64'(wr_en), 64'd0);

    // contention from reset: req0 then req1
    pulse_rst();
    set_req(0, 1'b1, 5'd3, 32'd1);
    set_req(1, 1'b1, 5'd4, 32'd2);
    #1;
    check("cont_ready0", 64'(rif.req_ready), 64'b01);
    push_exp(5'd3, 32'd1);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("cont_ready1", 64'(rif.req_ready), 64'b10);
    check("cont_addr0", 64'(wr_addr), 64'd3);
    check("cont_gid0", 64'(grant_id), 64'd0);
    push_exp(5'd4, 32'd2);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("cont_addr1", 64'(wr_addr), 64'd4);
    check("cont_gid1", 64'(grant_id), 64'd1);
    check("cont_wr_en1", 64'(wr_en), 64'd1);

    // both held valid: grants alternate 0,1,0,1
    set_req(0, 1'b1, 5'd6, 32'hA);
    set_req(1, 1'b1, 5'd7, 32'hB);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rr_ready", 64'(rif.req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
      if (c % 2 == 0) push_exp(5'd6, 32'hA);
      else            push_exp(5'd7, 32'hB);
      tick();
      check("rr_gid", 64'(grant_id), 64'(c % 2));
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();

    // x0 write: handshake completes, no write pulse
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    check("x0_ready", 64'(rif.req_ready), 64'b10);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("x0_wr_en", 64'(wr_en), 64'd0);
    check("x0_wr_addr", 64'(wr_addr), 64'd0);
    check("x0_wr_data", 64'(wr_data), 64'h1234);
    check("x0_grant_id", 64'(grant_id), 64'd1);

    // move rr_ptr to 1, then flush with both valid
    set_req(0, 1'b1, 5'd9, 32'h55);
    push_exp(5'd9, 32'h55);
    tick();
    set_req(0, 1'b1, 5'd10, 32'hC);
    set_req(1, 1'b1, 5'd11, 32'hD);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(rif.req_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_wr_en", 64'(wr_en), 64'd0);
    check("post_flush_ready", 64'(rif.req_ready), 64'b01);
    push_exp(5'd10, 32'hC);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("post_flush_gid0", 64'(grant_id), 64'd0);
    push_exp(5'd11, 32'hD);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("post_flush_gid1", 64'(grant_id), 64'd1);
    check("post_flush_addr1", 64'(wr_addr), 64'd11);
    tick();

    // async reset cancels a pending write pulse
    set_req(0, 1'b1, 5'd12, 32'hE);
    push_exp(5'd12, 32'hE);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("pre_rst_wr_en", 64'(wr_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    check("lost_write_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    #2 rst = 1'b0;
    tick();

`ifdef REGFILE_WB_ARB_STALL_CNT_EN
    // both valid continuously: one requester stalls on every edge
    check("stall_reset", 64'(stall_cnt), 64'd0);
    set_req(0, 1'b1, 5'd13, 32'h13);
    set_req(1, 1'b1, 5'd14, 32'h14);
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) push_exp(5'd13, 32'h13);
      else            push_exp(5'd14, 32'h14);
      tick();
    end
    check("stall_10", 64'(stall_cnt), 64'd10);
    for (int c = 10; c < 65540; c++) begin
      if (c % 2 == 0) push_exp(5'd13, 32'h13);
      else            push_exp(5'd14, 32'h14);
      tick();
    end
    check("stall_sat", 64'(stall_cnt), 64'hFFFF);
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    tick();
    check("stall_hold", 64'(stall_cnt), 64'hFFFF);
`endif

    tick();
    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
